// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC register and IF/ID pipeline register with boot/run/halt sequencing
module fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] MAX_INSADDR = 32'hffff_fff8,
    parameter logic [31:0] NOP_INS     = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] NPC,
    input  logic        clr,
    input  logic        stall,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC,
    output logic [31:0] IF_INS,
    output logic [31:0] ID_PC,
    output logic [31:0] ID_INS,
    output logic [31:0] ID_PCPLUS4,
    output logic        ID_valid,
    output logic        halted,
    output logic [31:0] fetch_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_d, id_pc_d, id_ins_d, id_pcplus4_d, fetch_d;
    logic [15:0] flush_d;
    logic        id_valid_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_BOOT;
            PC         <= RESET_PC;
            ID_PC      <= 32'd0;
            ID_INS     <= 32'd0;
            ID_PCPLUS4 <= 32'd0;
            ID_valid   <= 1'b0;
            fetch_cnt  <= 32'd0;
            flush_cnt  <= 16'd0;
        end else begin
            state_q    <= state_d;
            PC         <= pc_d;
            ID_PC      <= id_pc_d;
            ID_INS     <= id_ins_d;
            ID_PCPLUS4 <= id_pcplus4_d;
            ID_valid   <= id_valid_d;
            fetch_cnt  <= fetch_d;
            flush_cnt  <= flush_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = PC;
        id_pc_d      = ID_PC;
        id_ins_d     = ID_INS;
        id_pcplus4_d = ID_PCPLUS4;
        id_valid_d   = ID_valid;
        fetch_d      = fetch_cnt;
        flush_d      = flush_cnt;
        case (state_q)
            S_BOOT: begin
                state_d    = S_RUN;
                id_ins_d   = NOP_INS;
                id_valid_d = 1'b0;
            end
            S_RUN: begin
                // Under stall the branch operands are not ready, so clr is not trusted.
                if (stall) begin
                    state_d = S_RUN;
                end else if (clr) begin
                    pc_d       = NPC;
                    id_ins_d   = NOP_INS;
                    id_valid_d = 1'b0;
                    flush_d    = (flush_cnt == '1) ? flush_cnt : flush_cnt + 16'd1;
                end else begin
                    id_pc_d      = PC;
                    id_ins_d     = imem_rdata;
                    id_pcplus4_d = PC + 32'd4;
                    id_valid_d   = 1'b1;
                    fetch_d      = (fetch_cnt == '1) ? fetch_cnt : fetch_cnt + 32'd1;
                    // NPC is undefined past the last instruction; hold PC instead.
                    if (PC >= MAX_INSADDR) begin
                        state_d = S_HALT;
                    end else begin
                        pc_d = NPC;
                    end
                end
            end
            S_HALT: begin
                if (stall) begin
                    state_d = S_HALT;
                end else if (clr) begin
                    state_d    = S_RUN;
                    pc_d       = NPC;
                    id_ins_d   = NOP_INS;
                    id_valid_d = 1'b0;
                    flush_d    = (flush_cnt == '1) ? flush_cnt : flush_cnt + 16'd1;
                end else begin
                    id_ins_d   = NOP_INS;
                    id_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    assign IF_INS = (state_q == S_RUN) ? imem_rdata : NOP_INS;
    assign halted = (state_q == S_HALT);

endmodule
